// File: rtl/param_mux_arbiter_if.sv
// Bus bundle for param_mux_arbiter: per-channel valid/ready/data from the producers plus the
// registered output word towards the single consumer.
//   mode          : 0 = direct select, 1 = round-robin
//   selector_bits : channel index used in direct-select mode
//   in_valid      : per-channel data valid (producer -> block)
//   in_data       : packed channel data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready      : per-channel accept (block -> producer)
//   out_valid     : output register holds a word
//   out_data      : registered selected word
//   out_channel   : channel that supplied out_data
//   out_ready     : consumer accepts out_data
// Modport slave is the arbiter's view, modport master is the producer/consumer side.
interface param_mux_arbiter_if #(
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SEL_WIDTH    = $clog2(NUM_CHANNELS)
);
  logic                               mode;
  logic [SEL_WIDTH-1:0]               selector_bits;
  logic [NUM_CHANNELS-1:0]            in_valid;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data;
  logic [NUM_CHANNELS-1:0]            in_ready;
  logic                               out_valid;
  logic [DATA_WIDTH-1:0]              out_data;
  logic [SEL_WIDTH-1:0]               out_channel;
  logic                               out_ready;

  modport slave (
    input  mode, selector_bits, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_channel
  );

  modport master (
    output mode, selector_bits, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_channel
  );
endinterface

// File: rtl/param_mux_arbiter.sv
// N-channel, W-bit registered multiplexer with per-channel valid/ready handshaking and a
// one-entry output register. Selection is either direct (selector_bits) or round-robin.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : param_mux_arbiter_if.slave (see interface file for signal list)
// A word accepted on an input appears at the output one cycle later; with out_ready held high
// the block sustains one word per cycle.
module param_mux_arbiter #(
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SEL_WIDTH    = $clog2(NUM_CHANNELS)
) (
  input logic                 clk,
  input logic                 reset,
  param_mux_arbiter_if.slave  bus
);

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [SEL_WIDTH-1:0]  out_channel_q;
  logic [SEL_WIDTH-1:0]  last_grant_q;

  logic                  load_en;
  logic                  have_grant;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  int unsigned           rr_idx;

  // Output register can take a new word when empty or being drained this cycle.
  assign load_en = !out_valid_q || bus.out_ready;

  always_comb begin : grant_select
    have_grant = 1'b0;
    grant_idx  = '0;
    rr_idx     = 0;
    if (!bus.mode) begin
      // Loop compare instead of direct indexing so out-of-range selectors simply never match.
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        if (bus.selector_bits == SEL_WIDTH'(i) && bus.in_valid[i]) begin
          have_grant = 1'b1;
          grant_idx  = SEL_WIDTH'(i);
        end
      end
    end else begin
      // Offsets scanned from farthest to nearest so the channel right after last_grant
      // is written last and therefore wins.
      for (int unsigned k = NUM_CHANNELS; k > 0; k--) begin
        rr_idx = (32'(last_grant_q) + k) % NUM_CHANNELS;
        if (bus.in_valid[rr_idx]) begin
          have_grant = 1'b1;
          grant_idx  = SEL_WIDTH'(rr_idx);
        end
      end
    end
  end

  always_comb begin : data_select
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (grant_idx == SEL_WIDTH'(i)) begin
        grant_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin : ready_gen
    bus.in_ready = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      bus.in_ready[i] = have_grant && load_en && (grant_idx == SEL_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      // Start one below channel 0 so the first round-robin search begins at channel 0.
      last_grant_q  <= SEL_WIDTH'(NUM_CHANNELS - 1);
    end else if (load_en) begin
      if (have_grant) begin
        out_valid_q   <= 1'b1;
        out_data_q    <= grant_data;
        out_channel_q <= grant_idx;
        if (bus.mode) begin
          last_grant_q <= grant_idx;
        end
      end else begin
        // Nothing to load: drop valid, keep the last word visible on the data lines.
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_channel = out_channel_q;

endmodule

// File: tb/tb_param_mux_arbiter.sv
// Directed self-checking bench for param_mux_arbiter: an 8-channel instance for the main
// behaviour and a 10-channel instance (4-bit selector) for out-of-range selector handling.
module tb_param_mux_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  param_mux_arbiter_if #(.NUM_CHANNELS(8),  .DATA_WIDTH(8)) bus8 ();
  param_mux_arbiter_if #(.NUM_CHANNELS(10), .DATA_WIDTH(8)) bus10 ();

  param_mux_arbiter #(.NUM_CHANNELS(8), .DATA_WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  param_mux_arbiter #(.NUM_CHANNELS(10), .DATA_WIDTH(8)) dut10 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus10.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus8.mode = 1'b0;
    bus8.selector_bits = '0;
    bus8.in_valid = '0;
    bus8.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus8.in_data[i*8 +: 8] = 8'hA0 | 8'(i);
    bus10.mode = 1'b0;
    bus10.selector_bits = '0;
    bus10.in_valid = '0;
    bus10.in_data = '0;
    bus10.out_ready = 1'b1;

    step();
    step();
    check_eq("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus8.out_data), 32'h00);
    check_eq("rst_out_channel", 32'(bus8.out_channel), 32'd0);
    reset = 1'b0;

    // Out-of-range selector on the 10-channel build.
    bus10.in_valid = 10'h3FF;
    bus10.selector_bits = 4'd9;
    #1;
    check_eq("n10_sel9_ready", 32'(bus10.in_ready), 32'h200);
    bus10.selector_bits = 4'd12;
    #1;
    check_eq("n10_sel12_ready", 32'(bus10.in_ready), 32'h000);

    // Direct select, channel 5.
    bus8.mode = 1'b0;
    bus8.selector_bits = 3'd5;
    bus8.in_valid = 8'hFF;
    bus8.out_ready = 1'b1;
    #1;
    check_eq("dir_in_ready", 32'(bus8.in_ready), 32'h20);
    step();
    check_eq("dir_out_valid", 32'(bus8.out_valid), 32'd1);
    check_eq("dir_out_data", 32'(bus8.out_data), 32'hA5);
    check_eq("dir_out_channel", 32'(bus8.out_channel), 32'd5);

    // Selected channel not valid: no grant even though others are valid.
    bus8.selector_bits = 3'd4;
    bus8.in_valid = 8'hEF;
    #1;
    check_eq("dir_sel_invalid_ready", 32'(bus8.in_ready), 32'h00);

    // Asynchronous reset mid-cycle while holding a word.
    bus8.in_valid = 8'h00;
    bus8.out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_valid", 32'(bus8.out_valid), 32'd0);
    check_eq("async_rst_data", 32'(bus8.out_data), 32'h00);
    check_eq("async_rst_channel", 32'(bus8.out_channel), 32'd0);
    step();
    reset = 1'b0;

    // Round-robin fairness: 0..7 then 0, one word per cycle.
    bus8.mode = 1'b1;
    bus8.in_valid = 8'hFF;
    bus8.out_ready = 1'b1;
    #1;
    check_eq("rr_first_ready", 32'(bus8.in_ready), 32'h01);
    for (int k = 0; k < 9; k++) begin
      step();
      check_eq($sformatf("rr_chan_%0d", k), 32'(bus8.out_channel), 32'(k % 8));
      check_eq($sformatf("rr_data_%0d", k), 32'(bus8.out_data), 32'(8'hA0 | 8'(k % 8)));
      check_eq($sformatf("rr_valid_%0d", k), 32'(bus8.out_valid), 32'd1);
    end

    // Continue to a grant on channel 6 (1..6).
    for (int k = 1; k <= 6; k++) step();
    check_eq("rr_reach6", 32'(bus8.out_channel), 32'd6);

    // Skip and wrap with only channels 0 and 2 valid.
    bus8.in_valid = 8'b0000_0101;
    #1;
    check_eq("wrap_ready_0", 32'(bus8.in_ready), 32'h01);
    step();
    check_eq("wrap_chan_0", 32'(bus8.out_channel), 32'd0);
    #1;
    check_eq("wrap_ready_2", 32'(bus8.in_ready), 32'h04);
    step();
    check_eq("wrap_chan_2", 32'(bus8.out_channel), 32'd2);
    step();
    check_eq("wrap_chan_0b", 32'(bus8.out_channel), 32'd0);
    check_eq("wrap_data_0b", 32'(bus8.out_data), 32'hA0);

    // Backpressure for 4 cycles.
    bus8.in_valid = 8'hFF;
    bus8.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq($sformatf("stall_ready_%0d", k), 32'(bus8.in_ready), 32'h00);
      step();
      check_eq($sformatf("stall_valid_%0d", k), 32'(bus8.out_valid), 32'd1);
      check_eq($sformatf("stall_data_%0d", k), 32'(bus8.out_data), 32'hA0);
      check_eq($sformatf("stall_chan_%0d", k), 32'(bus8.out_channel), 32'd0);
    end
    bus8.out_ready = 1'b1;
    #1;
    check_eq("release_ready", 32'(bus8.in_ready), 32'h02);
    step();
    check_eq("release_chan", 32'(bus8.out_channel), 32'd1);
    check_eq("release_data", 32'(bus8.out_data), 32'hA1);
    check_eq("release_valid", 32'(bus8.out_valid), 32'd1);

    // Idle drain.
    bus8.in_valid = 8'h00;
    step();
    check_eq("drain_valid", 32'(bus8.out_valid), 32'd0);
    check_eq("drain_data", 32'(bus8.out_data), 32'hA1);
    check_eq("drain_chan", 32'(bus8.out_channel), 32'd1);

    // Direct transfer does not move last_grant; round-robin resumes after channel 1.
    bus8.mode = 1'b0;
    bus8.selector_bits = 3'd3;
    bus8.in_valid = 8'hFF;
    step();
    check_eq("modesw_dir_chan", 32'(bus8.out_channel), 32'd3);
    bus8.mode = 1'b1;
    step();
    check_eq("modesw_rr_chan", 32'(bus8.out_channel), 32'd2);
    check_eq("modesw_rr_data", 32'(bus8.out_data), 32'hA2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
